// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants and helpers for the clock display path
package clock_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 4;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 6'b111111;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] nibble);
        return nibble <= 4'd9;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divide-by-DIV counter with one-clock tick
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick_o) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick_o = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - six-digit BCD scan multiplexer with blink, DP, blanking and anode guard
module display_scan_mux
    import clock_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2,
    parameter int GUARD    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS*BCD_W-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]         blink_mask_i,
    input  logic [NUM_DIGITS-1:0]         dp_mask_i,
    input  logic                          lz_blank_i,
    output logic [BCD_W-1:0]              num_o,
    output logic                          blank_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic                          dp_o
);

    localparam int DIV  = CLK_HZ / SCAN_HZ;
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int GW   = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    logic                  scan_tick;
    logic                  blink_tick;
    logic [IW-1:0]         idx;
    logic [GW-1:0]         guard;
    logic                  blink_phase;

    logic [BCD_W-1:0]      nib;
    logic                  blank_next;
    logic [NUM_DIGITS-1:0] an_next;
    logic                  dp_next;

    tick_gen #(.DIV(DIV)) u_scan_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (scan_tick)
    );

    tick_gen #(.DIV(HALF)) u_blink_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (blink_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            guard       <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (scan_tick) begin
                idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                guard <= GW'(GUARD);
            end else if (guard != '0) begin
                guard <= guard - 1'b1;
            end
            if (blink_tick) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    // Blanking only gates segments; the anode still fires so every digit gets equal on-time.
    always_comb begin
        nib        = digits_i[BCD_W*idx +: BCD_W];
        blank_next = !bcd_valid(nib)
                   || (blink_mask_i[idx] && blink_phase)
                   || ((idx == IW'(NUM_DIGITS - 1)) && lz_blank_i && (nib == '0));
        an_next    = (guard != '0) ? AN_OFF : ~(NUM_DIGITS'(1) << idx);
        dp_next    = ~(dp_mask_i[idx] & ~blank_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_o   <= '0;
            blank_o <= 1'b1;
            an_o    <= AN_OFF;
            dp_o    <= 1'b1;
        end else begin
            num_o   <= nib;
            blank_o <= blank_next;
            an_o    <= an_next;
            dp_o    <= dp_next;
        end
    end

endmodule
